// File: rtl/por_rst_seq.sv
// por_rst_seq: staggered per-domain reset release downstream of the POR macro.
// Clocked by the POR RC oscillator. porb clears everything asynchronously.
// force_pdn holds every domain in reset. A software request restarts the
// release sequence once per assertion.

// ---------------------------------------------------------------------------
// por_rst_seq_sync: N-flop synchronizer with asynchronous clear to 0.
// The reset-release chain uses it with i_d tied high. The asynchronous
// debug and request inputs use it as a plain level synchronizer.
// ---------------------------------------------------------------------------
module por_rst_seq_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the input through the chain. porb low empties it immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// ---------------------------------------------------------------------------
// por_rst_seq: top level of the reset sequencer.
//
// Software reset handshake (level request, pulse acknowledge):
//   i_sw_rst_req is a level. It is accepted once, in RUN, when it is armed.
//   The request is armed out of reset and re-armed on any edge where the
//   synchronized request is low.
//   o_sw_rst_ack pulses for one cycle when rst_n[0] is released after that
//   restart. The requester must drop the request after the ack. A request
//   that stays high never starts a second restart.
// ---------------------------------------------------------------------------
module por_rst_seq #(
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_DLY   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_osc_ck,
    input  logic                   i_porb,
    input  logic                   i_force_pdn,
    input  logic                   i_sw_rst_req,
    output logic                   o_sw_rst_ack,
    output logic [NUM_DOMAINS-1:0] o_rst_n,
    output logic                   o_seq_done,
    output logic [1:0]             o_seq_state,
    output logic [7:0]             o_sw_rst_cnt
);

    // The encodings double as the debug state code on o_seq_state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // The counter runs 0..STAGE_DLY-1. A domain is released on the edge
    // where the counter would reach STAGE_DLY.
    localparam logic [7:0] STAGE_LAST = 8'(STAGE_DLY - 1);
    localparam logic [2:0] IDX_LAST   = 3'(NUM_DOMAINS - 1);
    localparam logic [7:0] CNT_MAX    = 8'hFF;

    // Synchronized inputs
    logic w_por_ok;
    logic w_fpd_s;
    logic w_req_s;

    // Registered state and outputs
    state_t                 r_state;
    logic [7:0]             r_stage_cnt;
    logic [2:0]             r_rel_idx;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic                   r_seq_done;
    logic                   r_ack;
    logic [7:0]             r_sw_cnt;
    logic                   r_armed;
    logic                   r_sw_restart;

    // Next-state values
    state_t                 w_state_nxt;
    logic [7:0]             w_stage_cnt_nxt;
    logic [2:0]             w_rel_idx_nxt;
    logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
    logic                   w_seq_done_nxt;
    logic                   w_ack_nxt;
    logic [7:0]             w_sw_cnt_nxt;
    logic                   w_armed_nxt;
    logic                   w_sw_restart_nxt;

    // One-hot select of the next domain to release
    logic [NUM_DOMAINS-1:0] w_rel_mask;
    logic                   w_stage_hit;

    // The deassertion of porb is synchronized by shifting in a constant 1.
    por_rst_seq_sync #(.STAGES(SYNC_STAGES)) u_por_sync (
        .i_clk   (i_osc_ck),
        .i_rst_n (i_porb),
        .i_d     (1'b1),
        .o_q     (w_por_ok)
    );

    por_rst_seq_sync #(.STAGES(SYNC_STAGES)) u_fpd_sync (
        .i_clk   (i_osc_ck),
        .i_rst_n (i_porb),
        .i_d     (i_force_pdn),
        .o_q     (w_fpd_s)
    );

    por_rst_seq_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .i_clk   (i_osc_ck),
        .i_rst_n (i_porb),
        .i_d     (i_sw_rst_req),
        .o_q     (w_req_s)
    );

    // Decode the release index into a mask of the domain released next.
    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (r_rel_idx == 3'(i)) begin
                w_rel_mask[i] = 1'b1;
            end
        end
    end

    assign w_stage_hit = (r_stage_cnt == STAGE_LAST);

    // Next state, stage timing, per-domain resets and request bookkeeping.
    always_comb begin
        w_state_nxt      = r_state;
        w_stage_cnt_nxt  = r_stage_cnt;
        w_rel_idx_nxt    = r_rel_idx;
        w_rst_n_nxt      = r_rst_n;
        w_seq_done_nxt   = r_seq_done;
        w_ack_nxt        = 1'b0;
        w_sw_cnt_nxt     = r_sw_cnt;
        w_sw_restart_nxt = r_sw_restart;
        // A low request re-arms the request. Nothing changes until the
        // reset chain has released.
        w_armed_nxt      = w_por_ok ? (r_armed | ~w_req_s) : r_armed;

        case (r_state)
            ST_IDLE: begin
                if (w_por_ok) begin
                    w_stage_cnt_nxt  = '0;
                    w_rel_idx_nxt    = '0;
                    w_rst_n_nxt      = '0;
                    w_seq_done_nxt   = 1'b0;
                    w_sw_restart_nxt = 1'b0;
                    w_state_nxt      = w_fpd_s ? ST_HOLD : ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (w_fpd_s) begin
                    // Abandon the partial release. Restart from domain 0 later.
                    w_state_nxt      = ST_HOLD;
                    w_stage_cnt_nxt  = '0;
                    w_rel_idx_nxt    = '0;
                    w_rst_n_nxt      = '0;
                    w_seq_done_nxt   = 1'b0;
                    w_sw_restart_nxt = 1'b0;
                end else if (w_stage_hit) begin
                    w_stage_cnt_nxt = '0;
                    w_rst_n_nxt     = r_rst_n | w_rel_mask;
                    // Only a software-initiated restart acknowledges, and
                    // only when domain 0 comes out of reset.
                    if (r_sw_restart && (r_rel_idx == 3'd0)) begin
                        w_ack_nxt        = 1'b1;
                        w_sw_restart_nxt = 1'b0;
                    end
                    if (r_rel_idx == IDX_LAST) begin
                        w_state_nxt    = ST_RUN;
                        w_seq_done_nxt = 1'b1;
                        w_rel_idx_nxt  = '0;
                    end else begin
                        w_rel_idx_nxt = r_rel_idx + 3'd1;
                    end
                end else begin
                    w_stage_cnt_nxt = r_stage_cnt + 8'd1;
                end
            end

            ST_RUN: begin
                // force_pdn wins. A request in the same cycle is dropped
                // and is not counted.
                if (w_fpd_s) begin
                    w_state_nxt    = ST_HOLD;
                    w_rst_n_nxt    = '0;
                    w_seq_done_nxt = 1'b0;
                end else if (w_req_s && r_armed) begin
                    w_state_nxt      = ST_RELEASE;
                    w_rst_n_nxt      = '0;
                    w_seq_done_nxt   = 1'b0;
                    w_stage_cnt_nxt  = '0;
                    w_rel_idx_nxt    = '0;
                    w_armed_nxt      = 1'b0;
                    w_sw_restart_nxt = 1'b1;
                    if (r_sw_cnt != CNT_MAX) begin
                        w_sw_cnt_nxt = r_sw_cnt + 8'd1;
                    end
                end
            end

            ST_HOLD: begin
                w_rst_n_nxt    = '0;
                w_seq_done_nxt = 1'b0;
                if (!w_fpd_s) begin
                    w_state_nxt     = ST_RELEASE;
                    w_stage_cnt_nxt = '0;
                    w_rel_idx_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers. porb low clears them asynchronously.
    always_ff @(posedge i_osc_ck or negedge i_porb) begin
        if (!i_porb) begin
            r_state      <= ST_IDLE;
            r_stage_cnt  <= '0;
            r_rel_idx    <= '0;
            r_rst_n      <= '0;
            r_seq_done   <= 1'b0;
            r_ack        <= 1'b0;
            r_sw_cnt     <= '0;
            r_armed      <= 1'b1;
            r_sw_restart <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stage_cnt  <= w_stage_cnt_nxt;
            r_rel_idx    <= w_rel_idx_nxt;
            r_rst_n      <= w_rst_n_nxt;
            r_seq_done   <= w_seq_done_nxt;
            r_ack        <= w_ack_nxt;
            r_sw_cnt     <= w_sw_cnt_nxt;
            r_armed      <= w_armed_nxt;
            r_sw_restart <= w_sw_restart_nxt;
        end
    end

    assign o_rst_n      = r_rst_n;
    assign o_seq_done   = r_seq_done;
    assign o_sw_rst_ack = r_ack;
    assign o_seq_state  = r_state;
    assign o_sw_rst_cnt = r_sw_cnt;

endmodule

// File: doc/por_rst_seq.md
# por_rst_seq

Digital reset sequencer that sits directly downstream of the POR macro. It consumes `porb` and the POR's internal RC clock `osc_ck`, and releases a set of per-domain active-low resets in a fixed, staggered order. It also re-runs the sequence on a software reset request or while the debug `force_pdn` is held, and it reports progress for bring-up.

## Interface
- `NUM_DOMAINS`, 4: number of sequenced reset outputs (1..8).
- `STAGE_DLY`, 16: `osc_ck` cycles between successive domain releases (2..255).
- `SYNC_STAGES`, 2: flop depth of every input synchronizer (2..4).

- `osc_ck`  in  1: sequencer clock, from POR oscillator.
- `porb`  in  1: reset. Asynchronous assert, active-low; deassertion is synchronized internally.
- `force_pdn`  in  1: debug. While high, all domains are held in reset. Asynchronous input.
- `sw_rst_req`  in  1: software reset request, level. Asynchronous input.
- `sw_rst_ack`  out  1: one-cycle pulse, request serviced.
- `rst_n`  out  NUM_DOMAINS: per-domain active-low resets. Bit 0 is released first.
- `seq_done`  out  1: high when all domains are released.
- `seq_state`  out  2: debug state, 0 IDLE, 1 RELEASE, 2 RUN, 3 HOLD.
- `sw_rst_cnt`  out  8: count of accepted software resets. Saturates at 255.

## Operation
- Reset behaviour: `porb` low asynchronously clears all state and outputs.
  - `rst_n` = 0, `seq_done` = 0, `sw_rst_ack` = 0, `seq_state` = 0, `sw_rst_cnt` = 0.
  - All synchronizer flops clear to 0.
- Reset deassertion synchronizer: a `SYNC_STAGES`-deep chain clocked by `osc_ck`, async-cleared by `porb`, shifting in 1.
  - All other logic is held in IDLE until the chain output is high.
- `force_pdn` and `sw_rst_req` each pass through a `SYNC_STAGES` synchronizer. The synchronized values are `fpd_s` and `req_s`.
- FSM:
  - IDLE:
    - Leaves when the reset chain output is high.
    - Goes to HOLD if `fpd_s` = 1, otherwise to RELEASE.
    - The stage counter clears to 0.
  - RELEASE:
    - The stage counter increments each cycle.
    - When it reaches `STAGE_DLY`, the next unreleased `rst_n` bit goes high and the counter returns to 0.
    - After bit `NUM_DOMAINS`-1 is released, go to RUN and set `seq_done` = 1 on the same edge.
  - RUN: holds all outputs.
    - If `fpd_s` = 1, go to HOLD.
    - Otherwise, if `req_s` = 1 and the request is armed: accept the request, go to RELEASE, clear all `rst_n` and `seq_done`, clear the counter, increment `sw_rst_cnt` (saturating), and disarm.
  - HOLD:
    - All `rst_n` = 0 and `seq_done` = 0.
    - Leaves to RELEASE with the counter at 0 on the first edge with `fpd_s` = 0.
  - From RELEASE, `fpd_s` = 1 also goes to HOLD, clearing any partially released domains.
- Priority: `fpd_s` wins over `req_s` in the same cycle. A request seen while `fpd_s` = 1 is not accepted and not counted.
- Arming: the request becomes armed at reset. It is re-armed on any edge where `req_s` = 0.
  - The requester must drop `sw_rst_req` after the ack.
  - A request held high continuously never causes a second reset.
- Requests are accepted only in RUN. A request held through RELEASE is accepted on arrival in RUN, if armed.
- `sw_rst_ack`: a one-cycle pulse on the edge that releases `rst_n[0]` after a software-initiated restart. There is no ack after a POR or HOLD restart.
- All outputs are registered.

## Timing
- Edge numbering: edge 1 is the first `osc_ck` rise with `porb` high.
  - The reset chain output is high after edge `SYNC_STAGES`.
  - `rst_n[i]` rises at edge `SYNC_STAGES` + 1 + (i+1)·`STAGE_DLY`.
  - Defaults: edges 19, 35, 51, 67. `seq_done` rises at edge 67.
- Software reset accepted at edge A:
  - `rst_n` = 0 and `seq_done` = 0 after A.
  - `rst_n[i]` rises at A + (i+1)·`STAGE_DLY`.
  - `sw_rst_ack` is high for the cycle after A + `STAGE_DLY`.
- Input latency: `sw_rst_req` or `force_pdn` rising before edge k is seen by the FSM at edge k + `SYNC_STAGES`. The outputs change on that edge.
- Leaving HOLD at edge H: `rst_n[i]` rises at H + (i+1)·`STAGE_DLY`.
- `porb` falling mid-sequence: outputs clear immediately, asynchronously to `osc_ck`.

## Test plan
- POR release, defaults: `porb` 0→1 → `rst_n` = 0001, 0011, 0111, 1111 at edges 19/35/51/67; `seq_done` at 67; `seq_state` 0→1→2.
- Software reset: in RUN, pulse `sw_rst_req` high for 5 cycles → all `rst_n` low 3 edges later; `sw_rst_cnt` = 1; `rst_n[0]` high 16 edges after accept with a 1-cycle `sw_rst_ack`; 1111 after 64 edges.
- Held request: `sw_rst_req` held high through a full resequence → exactly one reset, `sw_rst_cnt` = 1; drop and re-raise → `sw_rst_cnt` = 2.
- `force_pdn` mid-RELEASE with `rst_n` = 0011 → all 0, `seq_state` = 3; with a simultaneous `sw_rst_req` there is no count increment; on drop, release resumes from domain 0 at 16-cycle spacing with no ack.
- `porb` low mid-sequence, between clock edges → `rst_n`, `seq_done` and `sw_rst_cnt` clear immediately; the sequence restarts per the POR timing.
- Counter saturation: 260 armed requests → `sw_rst_cnt` = 255.
